hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RF_AW, default 5: register-index width.
REQ-002 SHALL have parameter MD_LAT, default 4: cycles a mul/div op occupies E (legal range 2..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have inputs opcode (5 bits, inst[6:2]), func3 (3), func7 (2, {inst[30],inst[25]}): D-stage instruction fields.
REQ-006 SHALL have inputs rs1, rs2, rd (RF_AW each): D-stage register indices.
REQ-007 SHALL have inputs alu_result0 (1 bit, E branch-taken flag) and dm_ready (1 bit, data memory accepts/returns this cycle).
REQ-008 SHALL have outputs stall (1 bit, hold PC and F/D register) and next_pc_sel (1 bit, redirect PC to jb target).
REQ-009 SHALL have outputs D_rs1_data_sel, D_rs2_data_sel (1 bit each): 1 = bypass W write data into D.
REQ-010 SHALL have outputs E_rs1_data_sel, E_rs2_data_sel (2 bits each): 1 = M result, 0 = W data, 2 = register file.
REQ-011 SHALL have outputs E_alu_op1_sel, E_alu_op2_sel, E_jb_op1_sel (1 bit each), E_op_out (5), E_f3_out (3), E_f7_out (2), E_md_busy (1).
REQ-012 SHALL have outputs M_dm_w_en (4 bits, byte strobes) and M_dm_req (1 bit, M access valid).
REQ-013 SHALL have outputs W_wb_en (1), W_rd_index (RF_AW), W_f3 (3), W_wb_data_sel (1, 1 = load data).

Function
REQ-014 SHALL keep E (op, f3, f7, rd, rs1, rs2), M (op, f3, rd) and W (op, f3, rd) stage registers; a bubble is op 00100 with all indices 0.
REQ-015 SHALL decode: uses_rs1 = {01100,00100,00000,01000,11000,11001}; uses_rs2 = {01100,01000,11000}; writes_rd = {01100,00100,00000,00101,01101,11001,11011}; other opcodes use and write nothing; index 0 never forms a hazard.
REQ-016 SHALL forward in E with priority M over W over register file; D bypass SHALL assert when the W rd matches the D source.
REQ-017 SHALL drive E selects {op1, op2, jb}: R 0/0/0; OP-IMM, LOAD, STORE, LUI 0/1/0; JALR, AUIPC 1/1/0; BRANCH 0/0/1; JAL 1/1/1; others 0/0/0.
REQ-018 SHALL set M_dm_req when M op is LOAD or STORE; M_dm_w_en for STORE by f3: 000 gives 0001, 001 gives 0011, 010 gives 1111, else 0000.
REQ-019 SHALL set W_wb_en = writes_rd(W op) and W_rd != 0, and W_wb_data_sel = (W op == LOAD).
REQ-020 SHALL detect load-use when E op is LOAD and a used D source equals a nonzero E rd: stall=1, D held, E gets a bubble, M/W advance.
REQ-021 SHALL set next_pc_sel=1 for E op JAL, JALR, or BRANCH with alu_result0=1; the next edge loads E with a bubble.
REQ-022 SHALL apply memory freeze when M_dm_req=1 and dm_ready=0: stall=1, next_pc_sel=0, E and M hold, W gets a bubble, and M_dm_w_en stays asserted.
REQ-023 SHALL apply mul/div occupancy when E op is 01100 and E f7[0]=1: on entry a 4-bit counter loads MD_LAT-1; while it is nonzero, E_md_busy=1, stall=1, next_pc_sel=0, E holds, M gets a bubble, W advances, and the counter decrements.
REQ-024 SHALL apply priority freeze > mul/div busy > redirect > load-use; the counter SHALL hold during freeze.
REQ-025 SHALL have E_op_out, E_f3_out and E_f7_out reflect the E registers combinationally.

Reset
REQ-026 SHALL, on a clock edge with rst=0, load all stage registers with bubbles and clear the counter, including mid-freeze or mid-mul/div.
REQ-027 SHALL, while in reset and on the first cycle after it, hold stall, next_pc_sel, E_md_busy, M_dm_req, M_dm_w_en, W_wb_en and all data-select outputs at 0, except E_rs*_data_sel = 2 and E_alu_op2_sel = 1 per the bubble.

Configuration
REQ-028 SHALL, with HAZARD_CTRL_MULDIV_EN defined, implement REQ-023.
REQ-029 SHALL, without HAZARD_CTRL_MULDIV_EN defined, omit the counter, tie E_md_busy to 0, and treat 01100 with f7[0]=1 as a single-cycle R-type.

Verification
REQ-030 SHALL cover: LW x5 followed by ADD x6,x5,x1 -> exactly one stall cycle with a bubble in E, then E_rs1_data_sel=0 (W forward).
REQ-031 SHALL cover: ADD x3 followed by SUB x4,x3,x3 -> E_rs1_data_sel=E_rs2_data_sel=1, stall=0.
REQ-032 SHALL cover: BEQ in E with alu_result0=1 -> next_pc_sel=1 for one cycle, then bubble in E; with alu_result0=0 -> next_pc_sel=0.
REQ-033 SHALL cover: SW with f3=010 in M and dm_ready low for 3 cycles -> stall=1 and M_dm_w_en=1111 for 3 cycles, W_wb_en=0, and advance on the 4th cycle.
REQ-034 SHALL cover: MUL in E with MD_LAT=4 and macro defined -> E_md_busy=1 and stall=1 for 3 cycles, then advance; macro undefined -> no stall.
REQ-035 SHALL cover: rst=0 asserted mid mul/div -> all outputs take reset values on the next edge and the counter is 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage RV32 core.
// Holds E/M/W instruction stage registers, drives the forwarding selects,
// load-use stall, branch/jump redirect, data-memory freeze and the optional
// mul/div occupancy stall (enabled by defining HAZARD_CTRL_MULDIV_EN).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   opcode/func3/func7  D-stage instruction fields; rs1/rs2/rd D-stage indices
//   alu_result0         E-stage branch taken; dm_ready data memory handshake
//   stall/next_pc_sel   hold PC + F/D, redirect PC to jump/branch target
//   D_*_data_sel        W write-data bypass into D
//   E_*                 E forwarding / ALU operand selects, E fields, md busy
//   M_dm_w_en/M_dm_req  data memory byte strobes and access valid
//   W_*                 write-back enable, index, func3, load-data select
module hazard_ctrl #(
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned MD_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [1:0]       func7,
    input  logic [RF_AW-1:0] rs1,
    input  logic [RF_AW-1:0] rs2,
    input  logic [RF_AW-1:0] rd,
    input  logic             alu_result0,
    input  logic             dm_ready,
    output logic             stall,
    output logic             next_pc_sel,
    output logic             D_rs1_data_sel,
    output logic             D_rs2_data_sel,
    output logic [1:0]       E_rs1_data_sel,
    output logic [1:0]       E_rs2_data_sel,
    output logic             E_alu_op1_sel,
    output logic             E_alu_op2_sel,
    output logic             E_jb_op1_sel,
    output logic [4:0]       E_op_out,
    output logic [2:0]       E_f3_out,
    output logic [1:0]       E_f7_out,
    output logic             E_md_busy,
    output logic [3:0]       M_dm_w_en,
    output logic             M_dm_req,
    output logic             W_wb_en,
    output logic [RF_AW-1:0] W_rd_index,
    output logic [2:0]       W_f3,
    output logic             W_wb_data_sel
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    function automatic logic uses_rs1(input logic [4:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_AUIPC) ||
               (op == OP_LUI) || (op == OP_JALR) || (op == OP_JAL);
    endfunction

    // E-stage source select: M result over W data over register file.
    function automatic logic [1:0] e_fwd(input logic used, input logic [RF_AW-1:0] src,
                                         input logic m_wr, input logic [RF_AW-1:0] m_idx,
                                         input logic w_wr, input logic [RF_AW-1:0] w_idx);
        if (!used || src == '0) return 2'd2;
        if (m_wr && m_idx == src) return 2'd1;
        if (w_wr && w_idx == src) return 2'd0;
        return 2'd2;
    endfunction

    logic [4:0]       e_op, m_op, w_op;
    logic [2:0]       e_f3, m_f3, w_f3;
    logic [1:0]       e_f7;
    logic [RF_AW-1:0] e_rd, e_rs1, e_rs2, m_rd, w_rd;

    logic m_mem, m_wr, w_wr, freeze, md_busy, redirect, load_use;
    logic op1_sel, op2_sel, jb_sel;
    logic [3:0] wen;

    assign m_mem    = (m_op == OP_LOAD) || (m_op == OP_STORE);
    assign m_wr     = writes_rd(m_op) && (m_rd != '0);
    assign w_wr     = writes_rd(w_op) && (w_rd != '0);
    assign freeze   = m_mem && !dm_ready;
    assign redirect = (e_op == OP_JAL) || (e_op == OP_JALR) || ((e_op == OP_BRANCH) && alu_result0);
    assign load_use = (e_op == OP_LOAD) && (e_rd != '0) &&
                      ((uses_rs1(opcode) && rs1 == e_rd) || (uses_rs2(opcode) && rs2 == e_rd));

`ifdef HAZARD_CTRL_MULDIV_EN
    // Remaining stall cycles of the mul/div op resident in E.
    logic [3:0] md_cnt;
    assign md_busy = (md_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            md_cnt <= 4'd0;
        end else if (freeze) begin
            md_cnt <= md_cnt;
        end else if (md_busy) begin
            md_cnt <= md_cnt - 4'd1;
        end else if (!redirect && !load_use && opcode == OP_R && func7[0]) begin
            md_cnt <= 4'(MD_LAT - 1);
        end else begin
            md_cnt <= 4'd0;
        end
    end
`else
    assign md_busy = 1'b0;
`endif

    // Stage registers; bubble is OP-IMM with all indices zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            e_op <= OP_IMM; e_f3 <= '0; e_f7 <= '0; e_rd <= '0; e_rs1 <= '0; e_rs2 <= '0;
            m_op <= OP_IMM; m_f3 <= '0; m_rd <= '0;
            w_op <= OP_IMM; w_f3 <= '0; w_rd <= '0;
        end else if (freeze) begin
            w_op <= OP_IMM; w_f3 <= '0; w_rd <= '0;
        end else begin
            w_op <= m_op; w_f3 <= m_f3; w_rd <= m_rd;
            if (md_busy) begin
                m_op <= OP_IMM; m_f3 <= '0; m_rd <= '0;
            end else begin
                m_op <= e_op; m_f3 <= e_f3; m_rd <= e_rd;
                if (redirect || load_use) begin
                    e_op <= OP_IMM; e_f3 <= '0; e_f7 <= '0; e_rd <= '0; e_rs1 <= '0; e_rs2 <= '0;
                end else begin
                    e_op <= opcode; e_f3 <= func3; e_f7 <= func7;
                    e_rd <= rd; e_rs1 <= rs1; e_rs2 <= rs2;
                end
            end
        end
    end

    // ALU / jump-branch operand selects by E opcode.
    always_comb begin
        op1_sel = 1'b0;
        op2_sel = 1'b0;
        jb_sel  = 1'b0;
        case (e_op)
            OP_IMM, OP_LOAD, OP_STORE, OP_LUI: op2_sel = 1'b1;
            OP_JALR, OP_AUIPC: begin op1_sel = 1'b1; op2_sel = 1'b1; end
            OP_BRANCH: jb_sel = 1'b1;
            OP_JAL: begin op1_sel = 1'b1; op2_sel = 1'b1; jb_sel = 1'b1; end
            default: ;
        endcase
    end

    // Store byte strobes.
    always_comb begin
        wen = 4'b0000;
        if (m_op == OP_STORE) begin
            case (m_f3)
                3'b000:  wen = 4'b0001;
                3'b001:  wen = 4'b0011;
                3'b010:  wen = 4'b1111;
                default: wen = 4'b0000;
            endcase
        end
    end

    // Control outputs are forced to their bubble values while reset is held.
    assign stall          = rst && (freeze || md_busy || (!redirect && load_use));
    assign next_pc_sel    = rst && !freeze && !md_busy && redirect;
    assign D_rs1_data_sel = rst && w_wr && uses_rs1(opcode) && (rs1 == w_rd);
    assign D_rs2_data_sel = rst && w_wr && uses_rs2(opcode) && (rs2 == w_rd);
    assign E_rs1_data_sel = rst ? e_fwd(uses_rs1(e_op), e_rs1, m_wr, m_rd, w_wr, w_rd) : 2'd2;
    assign E_rs2_data_sel = rst ? e_fwd(uses_rs2(e_op), e_rs2, m_wr, m_rd, w_wr, w_rd) : 2'd2;
    assign E_alu_op1_sel  = rst && op1_sel;
    assign E_alu_op2_sel  = !rst || op2_sel;
    assign E_jb_op1_sel   = rst && jb_sel;
    assign E_op_out       = e_op;
    assign E_f3_out       = e_f3;
    assign E_f7_out       = e_f7;
    assign E_md_busy      = rst && md_busy;
    assign M_dm_req       = rst && m_mem;
    assign M_dm_w_en      = rst ? wen : 4'b0000;
    assign W_wb_en        = rst && w_wr;
    assign W_rd_index     = w_rd;
    assign W_f3           = w_f3;
    assign W_wb_data_sel  = rst && (w_op == OP_LOAD);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized instruction streams, checked against an instruction-level model.
module tb_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;
`ifdef HAZARD_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [4:0] LOAD = 5'b00000, IMM = 5'b00100, AUIPC = 5'b00101,
                           STORE = 5'b01000, ROP = 5'b01100, LUI = 5'b01101,
                           BRANCH = 5'b11000, JALR = 5'b11001, JAL = 5'b11011;

    typedef struct packed {
        logic [4:0]    op;
        logic [2:0]    f3;
        logic [1:0]    f7;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
    } inst_t;

    typedef struct packed {
        logic          stall, npc, d1, d2;
        logic [1:0]    e1, e2;
        logic          op1, op2, jb;
        logic [4:0]    eop;
        logic [2:0]    ef3;
        logic [1:0]    ef7;
        logic          busy;
        logic [3:0]    wen;
        logic          req, wben;
        logic [AW-1:0] wrd;
        logic [2:0]    wf3;
        logic          wsel;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    opcode;
    logic [2:0]    func3;
    logic [1:0]    func7;
    logic [AW-1:0] rs1, rs2, rd;
    logic          alu_result0, dm_ready;
    logic          stall, next_pc_sel, D_rs1_data_sel, D_rs2_data_sel;
    logic [1:0]    E_rs1_data_sel, E_rs2_data_sel;
    logic          E_alu_op1_sel, E_alu_op2_sel, E_jb_op1_sel;
    logic [4:0]    E_op_out;
    logic [2:0]    E_f3_out;
    logic [1:0]    E_f7_out;
    logic          E_md_busy;
    logic [3:0]    M_dm_w_en;
    logic          M_dm_req, W_wb_en;
    logic [AW-1:0] W_rd_index;
    logic [2:0]    W_f3;
    logic          W_wb_data_sel;

    hazard_ctrl #(.RF_AW(AW), .MD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_result0(alu_result0), .dm_ready(dm_ready),
        .stall(stall), .next_pc_sel(next_pc_sel),
        .D_rs1_data_sel(D_rs1_data_sel), .D_rs2_data_sel(D_rs2_data_sel),
        .E_rs1_data_sel(E_rs1_data_sel), .E_rs2_data_sel(E_rs2_data_sel),
        .E_alu_op1_sel(E_alu_op1_sel), .E_alu_op2_sel(E_alu_op2_sel), .E_jb_op1_sel(E_jb_op1_sel),
        .E_op_out(E_op_out), .E_f3_out(E_f3_out), .E_f7_out(E_f7_out), .E_md_busy(E_md_busy),
        .M_dm_w_en(M_dm_w_en), .M_dm_req(M_dm_req),
        .W_wb_en(W_wb_en), .W_rd_index(W_rd_index), .W_f3(W_f3), .W_wb_data_sel(W_wb_data_sel)
    );

    // Reference model: instructions resident in E, M, W plus remaining mul/div stall cycles.
    inst_t me, mm, mw;
    int    md_left;
    out_t  exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic  last_stall;

    function automatic inst_t mk(input logic [4:0] op, input logic [2:0] f3, input logic [1:0] f7,
                                 input int d, input int s1, input int s2);
        inst_t i;
        i.op = op; i.f3 = f3; i.f7 = f7;
        i.rd = AW'(d); i.rs1 = AW'(s1); i.rs2 = AW'(s2);
        return i;
    endfunction

    function automatic inst_t bubble();
        return mk(IMM, 3'd0, 2'd0, 0, 0, 0);
    endfunction

    function automatic bit reads1(input logic [4:0] op);
        return op inside {ROP, IMM, LOAD, STORE, BRANCH, JALR};
    endfunction

    function automatic bit reads2(input logic [4:0] op);
        return op inside {ROP, STORE, BRANCH};
    endfunction

    function automatic bit writes(input inst_t i);
        return (i.op inside {ROP, IMM, LOAD, AUIPC, LUI, JALR, JAL}) && (i.rd != 0);
    endfunction

    // Where E gets a source operand: youngest older producer wins.
    function automatic logic [1:0] src_of(input bit used, input logic [AW-1:0] r);
        if (!used || r == 0) return 2'd2;
        if (writes(mm) && mm.rd == r) return 2'd1;
        if (writes(mw) && mw.rd == r) return 2'd0;
        return 2'd2;
    endfunction

    function automatic out_t expect_out(input inst_t d, input logic alu, input logic dmr,
                                        input logic rstv);
        out_t o;
        bit mem, frz, busy, redir, lu;
        mem   = mm.op inside {LOAD, STORE};
        frz   = mem && !dmr;
        busy  = md_left > 0;
        redir = (me.op == JAL) || (me.op == JALR) || (me.op == BRANCH && alu);
        lu    = (me.op == LOAD) && (me.rd != 0) &&
                ((reads1(d.op) && d.rs1 == me.rd) || (reads2(d.op) && d.rs2 == me.rd));
        o.stall = frz || busy || (lu && !redir);
        o.npc   = redir && !frz && !busy;
        o.d1    = writes(mw) && reads1(d.op) && d.rs1 == mw.rd;
        o.d2    = writes(mw) && reads2(d.op) && d.rs2 == mw.rd;
        o.e1    = src_of(reads1(me.op), me.rs1);
        o.e2    = src_of(reads2(me.op), me.rs2);
        o.op1   = me.op inside {JALR, AUIPC, JAL};
        o.op2   = me.op inside {IMM, LOAD, STORE, LUI, JALR, AUIPC, JAL};
        o.jb    = me.op inside {BRANCH, JAL};
        o.eop   = me.op;
        o.ef3   = me.f3;
        o.ef7   = me.f7;
        o.busy  = busy;
        o.wen   = 4'b0000;
        if (mm.op == STORE && mm.f3 == 3'b000) o.wen = 4'b0001;
        if (mm.op == STORE && mm.f3 == 3'b001) o.wen = 4'b0011;
        if (mm.op == STORE && mm.f3 == 3'b010) o.wen = 4'b1111;
        o.req   = mem;
        o.wben  = writes(mw);
        o.wrd   = mw.rd;
        o.wf3   = mw.f3;
        o.wsel  = mw.op == LOAD;
        if (!rstv) begin
            o.stall = 0; o.npc = 0; o.d1 = 0; o.d2 = 0; o.e1 = 2'd2; o.e2 = 2'd2;
            o.op1 = 0; o.op2 = 1; o.jb = 0; o.busy = 0; o.wen = 4'b0000;
            o.req = 0; o.wben = 0; o.wsel = 0;
        end
        return o;
    endfunction

    task automatic advance(input inst_t d, input logic alu, input logic dmr, input logic rstv);
        bit frz, redir, lu;
        frz   = (mm.op inside {LOAD, STORE}) && !dmr;
        redir = (me.op == JAL) || (me.op == JALR) || (me.op == BRANCH && alu);
        lu    = (me.op == LOAD) && (me.rd != 0) &&
                ((reads1(d.op) && d.rs1 == me.rd) || (reads2(d.op) && d.rs2 == me.rd));
        if (!rstv) begin
            me = bubble(); mm = bubble(); mw = bubble(); md_left = 0;
        end else if (frz) begin
            mw = bubble();
        end else if (md_left > 0) begin
            mw = mm; mm = bubble(); md_left--;
        end else if (redir || lu) begin
            mw = mm; mm = me; me = bubble();
        end else begin
            mw = mm; mm = me; me = d;
            md_left = (MD_EN && d.op == ROP && d.f7[0]) ? int'(LAT) - 1 : 0;
        end
    endtask

    // One cycle: present D, record expectation, then move the model across the edge.
    task automatic step(input inst_t d, input logic alu, input logic dmr, input logic rstv);
        out_t e;
        opcode = d.op; func3 = d.f3; func7 = d.f7;
        rd = d.rd; rs1 = d.rs1; rs2 = d.rs2;
        alu_result0 = alu; dm_ready = dmr; rst = rstv;
        e = expect_out(d, alu, dmr, rstv);
        last_stall = e.stall;
        exp_q.push_back(e);
        @(posedge clk);
        advance(d, alu, dmr, rstv);
        #1;
    endtask

    function automatic inst_t rand_inst();
        logic [4:0] ops[11];
        ops = '{LOAD, IMM, AUIPC, STORE, ROP, LUI, BRANCH, JALR, JAL, 5'b00011, 5'b11100};
        return mk(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        out_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{stall: stall, npc: next_pc_sel, d1: D_rs1_data_sel, d2: D_rs2_data_sel,
                  e1: E_rs1_data_sel, e2: E_rs2_data_sel, op1: E_alu_op1_sel,
                  op2: E_alu_op2_sel, jb: E_jb_op1_sel, eop: E_op_out, ef3: E_f3_out,
                  ef7: E_f7_out, busy: E_md_busy, wen: M_dm_w_en, req: M_dm_req,
                  wben: W_wb_en, wrd: W_rd_index, wf3: W_f3, wsel: W_wb_data_sel};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got=%h want=%h (stall %b/%b npc %b/%b e1 %0d/%0d busy %b/%b)",
                         $time, a, e, a.stall, e.stall, a.npc, e.npc, a.e1, e.e1, a.busy, e.busy);
            end
        end
    end

    initial begin
        inst_t nop, d;
        nop = bubble();
        me = nop; mm = nop; mw = nop; md_left = 0;
        opcode = IMM; func3 = 0; func7 = 0; rd = 0; rs1 = 0; rs2 = 0;
        alu_result0 = 0; dm_ready = 1; rst = 0;
        repeat (2) @(posedge clk);
        #1;
        step(nop, 0, 1, 0);
        step(nop, 0, 1, 1);

        // LW x5 then ADD x6,x5,x1: one load-use stall, then W forward.
        step(mk(LOAD, 3'b010, 2'b00, 5, 2, 0), 0, 1, 1);
        repeat (2) step(mk(ROP, 3'b000, 2'b00, 6, 5, 1), 0, 1, 1);
        repeat (3) step(nop, 0, 1, 1);

        // ADD x3 then SUB x4,x3,x3: both operands from M.
        step(mk(ROP, 3'b000, 2'b00, 3, 1, 2), 0, 1, 1);
        step(mk(ROP, 3'b000, 2'b10, 4, 3, 3), 0, 1, 1);
        repeat (3) step(nop, 0, 1, 1);

        // BEQ taken then not taken.
        step(mk(BRANCH, 3'b000, 2'b00, 0, 1, 2), 0, 1, 1);
        repeat (2) step(nop, 1, 1, 1);
        step(mk(BRANCH, 3'b000, 2'b00, 0, 1, 2), 0, 1, 1);
        repeat (2) step(nop, 0, 1, 1);

        // SW word with dm_ready low for three cycles.
        step(mk(STORE, 3'b010, 2'b00, 0, 1, 2), 0, 1, 1);
        step(nop, 0, 1, 1);
        repeat (3) step(nop, 0, 0, 1);
        repeat (3) step(nop, 0, 1, 1);

        // MUL occupancy.
        step(mk(ROP, 3'b000, 2'b01, 7, 1, 2), 0, 1, 1);
        repeat (6) step(mk(ROP, 3'b000, 2'b00, 8, 7, 7), 0, 1, 1);

        // Reset asserted while MUL is busy.
        step(mk(ROP, 3'b001, 2'b01, 9, 1, 2), 0, 1, 1);
        step(nop, 0, 1, 1);
        step(nop, 0, 1, 0);
        repeat (4) step(nop, 0, 1, 1);

        // Random streams; D is held while the model says the pipe stalls.
        d = rand_inst();
        for (int i = 0; i < 3000; i++) begin
            step(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) != 0));
            if (!last_stall) d = rand_inst();
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
